// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, ALUOp codes, FSM states.
// Also imported by the ALU control decoder.
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_IMM   = 2'b11
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EX    = 4'd6,
        S_R_WB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_I_EX    = 4'd10,
        S_I_WB    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ORI) ||
               (op == OP_XORI) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control-path bundle between the main control FSM (master) and the datapath (slave).
interface multi_cycle_control_if #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
);
    logic [OP_W-1:0] OpCode;
    logic            MemReady;
    logic            PCWrite;
    logic            PCWriteCond;
    logic            BranchNE;
    logic            IorD;
    logic            MemRead;
    logic            MemWrite;
    logic            IRWrite;
    logic            MemtoReg;
    logic            RegDst;
    logic            RegWrite;
    logic            ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [1:0]      ALUOp;
    logic [1:0]      PCSource;
    logic [ST_W-1:0] State;
    logic            Illegal;

    modport master (
        input  OpCode, MemReady,
        output PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               State, Illegal
    );

    modport slave (
        output OpCode, MemReady,
        input  PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               State, Illegal
    );
endinterface

// File: rtl/mc_next_state.sv
// Combinational next-state logic of the multi-cycle control FSM.
// MC_ILLEGAL_TRAP_EN: illegal opcodes trap into HALT instead of acting as a NOP.
module mc_next_state
    import mc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  state_t          state,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output state_t          state_next
);

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW)
                    state_next = S_MEM_ADR;
                else if (opcode == OP_R)
                    state_next = S_R_EX;
                else if (opcode == OP_BEQ || opcode == OP_BNE)
                    state_next = S_BRANCH;
                else if (opcode == OP_J)
                    state_next = S_JUMP;
                else if (is_imm_op(opcode))
                    state_next = S_I_EX;
                else
`ifdef MC_ILLEGAL_TRAP_EN
                    state_next = S_HALT;
`else
                    state_next = S_FETCH;
`endif
            end
            // OpCode is held by the IR, so it still selects load vs store here
            S_MEM_ADR: begin
                if (opcode == OP_LW)
                    state_next = S_MEM_RD;
                else if (opcode == OP_SW)
                    state_next = S_MEM_WR;
                else
                    state_next = S_FETCH;
            end
            S_MEM_RD: state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB: state_next = S_FETCH;
            S_MEM_WR: state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EX:   state_next = S_R_WB;
            S_R_WB:   state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_I_EX:   state_next = S_I_WB;
            S_I_WB:   state_next = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT:   state_next = S_HALT;
`endif
            default:  state_next = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle MIPS CPU: state register plus Moore output decode.
// MC_ILLEGAL_TRAP_EN: enables the HALT trap and the Illegal flag.
module multi_cycle_control
    import mc_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_cycle_control_if.master bus
);

    state_t state_reg;
    state_t state_next;
    logic   mem_ready_gated;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= S_FETCH;
        else
            state_reg <= state_next;
    end

    mc_next_state #(
        .OP_W(OP_W)
    ) u_next_state (
        .state      (state_reg),
        .opcode     (bus.OpCode),
        .mem_ready  (bus.MemReady),
        .state_next (state_next)
    );

    // While rst is high the FSM sits in FETCH; masking MemReady keeps PC/IR loads off.
    assign mem_ready_gated = bus.MemReady & ~rst;

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.BranchNE    = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = ALU_ADD;
        bus.PCSource    = 2'b00;
        case (state_reg)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = mem_ready_gated;
                bus.PCWrite = mem_ready_gated;
            end
            S_DECODE:  bus.ALUSrcB = 2'b11;
            S_MEM_ADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_R_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_RTYPE;
            end
            S_R_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.BranchNE    = (bus.OpCode == OP_BNE);
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            S_I_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = (bus.OpCode == OP_ADDI) ? ALU_ADD : ALU_IMM;
            end
            S_I_WB:  bus.RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign bus.State = ST_W'(state_reg);

`ifdef MC_ILLEGAL_TRAP_EN
    assign bus.Illegal = (state_reg == S_HALT);
`else
    assign bus.Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: per-cycle expectations queued by stimulus, checked by a monitor.
// Honours MC_ILLEGAL_TRAP_EN the same way as the design.
module tb_multi_cycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aop, psrc;
        logic ill;
    } outv_t;

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    outv_t exp_q[$];

    multi_cycle_control_if #(.OP_W(6), .ST_W(4)) bus ();

    multi_cycle_control #(.OP_W(6), .ST_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction class from the opcode: 0 R, 1 LW, 2 SW, 3 branch, 4 jump, 5 imm, 6 illegal
    function automatic int kind(input logic [5:0] op);
        case (op)
            6'h00: return 0;
            6'h23: return 1;
            6'h2B: return 2;
            6'h04, 6'h05: return 3;
            6'h02: return 4;
            6'h08, 6'h0A, 6'h0D, 6'h0E, 6'h0F: return 5;
            default: return 6;
        endcase
    endfunction

    // Expected outputs for a given state, straight from the control table
    function automatic outv_t expv(input logic [3:0] st, input logic [5:0] op, input logic mr);
        outv_t o;
        o = '0;
        o.st = st;
        case (st)
            4'd0:  begin o.mrd = 1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
            4'd1:  o.srcb = 2'b11;
            4'd2:  begin o.srca = 1; o.srcb = 2'b10; end
            4'd3:  begin o.mrd = 1; o.iord = 1; end
            4'd4:  begin o.rw = 1; o.m2r = 1; end
            4'd5:  begin o.mwr = 1; o.iord = 1; end
            4'd6:  begin o.srca = 1; o.aop = 2'b10; end
            4'd7:  begin o.rw = 1; o.rdst = 1; end
            4'd8:  begin o.srca = 1; o.aop = 2'b01; o.pcwc = 1; o.psrc = 2'b01; o.bne = (op == 6'h05); end
            4'd9:  begin o.pcw = 1; o.psrc = 2'b10; end
            4'd10: begin o.srca = 1; o.srcb = 2'b10; o.aop = (op == 6'h08) ? 2'b00 : 2'b11; end
            4'd11: o.rw = 1;
            4'd12: o.ill = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic outv_t sample();
        outv_t a;
        a.st = bus.State;   a.pcw = bus.PCWrite;   a.pcwc = bus.PCWriteCond;
        a.bne = bus.BranchNE; a.iord = bus.IorD;   a.mrd = bus.MemRead;
        a.mwr = bus.MemWrite; a.irw = bus.IRWrite; a.m2r = bus.MemtoReg;
        a.rdst = bus.RegDst;  a.rw = bus.RegWrite; a.srca = bus.ALUSrcA;
        a.srcb = bus.ALUSrcB; a.aop = bus.ALUOp;   a.psrc = bus.PCSource;
        a.ill = bus.Illegal;
        return a;
    endfunction

    always @(negedge clk) begin : monitor
        if (exp_q.size() > 0) begin
            outv_t e;
            outv_t a;
            e = exp_q.pop_front();
            a = sample();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t state act=%0d exp=%0d vec act=%h exp=%h",
                         $time, a.st, e.st, a, e);
            end
        end
    end

    task automatic drive_cycle(input logic [3:0] st, input logic mr, input logic r,
                               input logic [5:0] op);
        @(posedge clk);
        #1;
        rst          = r;
        bus.OpCode   = op;
        bus.MemReady = mr;
        exp_q.push_back(r ? expv(4'd0, op, 1'b0) : expv(st, op, mr));
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction: wf fetch stalls, wm memory stalls, abort_n>=0 resets after that many cycles
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int abort_n);
        step_t s[$];
        int    k;
        int    n;
        logic  need_rst;
        k = kind(op);
        need_rst = (abort_n >= 0);
        repeat (wf) s.push_back(step_t'{4'd0, 1'b0});
        s.push_back(step_t'{4'd0, 1'b1});
        s.push_back(step_t'{4'd1, rb()});
        case (k)
            0: begin s.push_back(step_t'{4'd6, rb()}); s.push_back(step_t'{4'd7, rb()}); end
            1: begin
                s.push_back(step_t'{4'd2, rb()});
                repeat (wm) s.push_back(step_t'{4'd3, 1'b0});
                s.push_back(step_t'{4'd3, 1'b1});
                s.push_back(step_t'{4'd4, rb()});
            end
            2: begin
                s.push_back(step_t'{4'd2, rb()});
                repeat (wm) s.push_back(step_t'{4'd5, 1'b0});
                s.push_back(step_t'{4'd5, 1'b1});
            end
            3: s.push_back(step_t'{4'd8, rb()});
            4: s.push_back(step_t'{4'd9, rb()});
            5: begin s.push_back(step_t'{4'd10, rb()}); s.push_back(step_t'{4'd11, rb()}); end
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                repeat (3) s.push_back(step_t'{4'd12, rb()});
                need_rst = 1'b1;
`endif
            end
        endcase
        n = 0;
        foreach (s[i]) begin
            if (abort_n >= 0 && i >= abort_n) break;
            drive_cycle(s[i].st, s[i].mr, 1'b0, op);
            n++;
        end
        if (need_rst) drive_cycle(4'd0, 1'b1, 1'b1, op);
        $display("instr op=%h kind=%0d cycles=%0d reset_after=%0d", op, k, n, need_rst);
    endtask

    logic [5:0] legal_ops [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                                   6'h08, 6'h0A, 6'h0D, 6'h0E, 6'h0F};

    initial begin : stim
        logic [5:0] op;
        bus.OpCode   = 6'h00;
        bus.MemReady = 1'b0;
        drive_cycle(4'd0, 1'b0, 1'b1, 6'h00);

        run_instr(6'h2B, 0, 2, 4);   // reset while stalled in MEM_WR
        run_instr(6'h00, 0, 0, -1);  // R-type, first fetch after reset loads IR
        run_instr(6'h23, 1, 3, -1);  // LW with three memory stalls
        run_instr(6'h05, 0, 0, -1);
        run_instr(6'h04, 0, 0, -1);
        run_instr(6'h08, 0, 0, -1);
        run_instr(6'h0F, 0, 0, -1);
        run_instr(6'h3F, 0, 0, -1);
        run_instr(6'h02, 0, 0, -1);
        run_instr(6'h2B, 0, 0, -1);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0)
                op = 6'($urandom_range(0, 63));
            else
                op = legal_ops[$urandom_range(0, 10)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3),
                      ($urandom_range(0, 15) == 0) ? $urandom_range(1, 4) : -1);
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending act=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
